// File: rtl/mem_arb_if.sv
// Fetch, data and single-port RAM signal bundle around mem_arb.
// master = requesters plus RAM model side, slave = the arbiter.
interface mem_arb_if #(
   parameter int unsigned AW = 10
);
   logic          i_ren;
   logic [31:0]   i_addr;
   logic          i_accept;
   logic          i_val;
   logic          i_error;
   logic [31:0]   i_rdata;
   logic [31:0]   i_pc;

   logic          d_ren;
   logic [3:0]    d_wen;
   logic [31:0]   d_addr;
   logic [31:0]   d_wdata;
   logic [10:0]   d_req_tag;
   logic          d_accept;
   logic          d_val;
   logic          d_error;
   logic [31:0]   d_rdata;
   logic [10:0]   d_resp_tag;

   logic          mem_ren;
   logic [3:0]    mem_wen;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [15:0]   conflict_cnt;

   modport master (
      output i_ren, i_addr, d_ren, d_wen, d_addr, d_wdata, d_req_tag, mem_rdata,
      input  i_accept, i_val, i_error, i_rdata, i_pc,
      input  d_accept, d_val, d_error, d_rdata, d_resp_tag,
      input  mem_ren, mem_wen, mem_addr, mem_wdata, conflict_cnt
   );

   modport slave (
      input  i_ren, i_addr, d_ren, d_wen, d_addr, d_wdata, d_req_tag, mem_rdata,
      output i_accept, i_val, i_error, i_rdata, i_pc,
      output d_accept, d_val, d_error, d_rdata, d_resp_tag,
      output mem_ren, mem_wen, mem_addr, mem_wdata, conflict_cnt
   );
endinterface

// File: rtl/mem_arb.sv
// Round-robin fetch/data arbiter for one single-port RAM; grant and RAM command in the request cycle.
// Response exactly one cycle after accept; the losing side holds its request, responses never stall.
module mem_arb #(
   parameter int unsigned AW        = 10,
   parameter logic [31:0] MEM_START = 32'h0000_0000,
   parameter logic [31:0] MEM_STOP  = 32'h0000_1000
) (
   input logic      clk,
   input logic      rst_n,
   mem_arb_if.slave bus
);
   logic        i_act;
   logic        d_act;
   logic        d_wr;
   logic        i_inr;
   logic        d_inr;
   logic        gnt_i;
   logic        gnt_d;

   logic        prio_q;
   logic        rsp_val_q;
   logic        rsp_src_q;
   logic        rsp_err_q;
   logic [10:0] rsp_tag_q;
   logic [31:0] rsp_pc_q;
   logic [15:0] cnt_q;

   logic        i_val_w;
   logic        d_val_w;

   // Offset from MEM_START wraps for addresses below it, so one unsigned compare covers both bounds.
   function automatic logic in_range(input logic [31:0] a);
      return ((a & ~32'h3) - MEM_START) < (MEM_STOP - MEM_START);
   endfunction

   assign i_act = bus.i_ren;
   assign d_wr  = |bus.d_wen;
   assign d_act = bus.d_ren | d_wr;
   assign i_inr = in_range(bus.i_addr);
   assign d_inr = in_range(bus.d_addr);

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   assign gnt_d = rst_n & d_act & (~i_act | prio_q);
   assign gnt_i = rst_n & i_act & ~gnt_d;

   assign bus.i_accept = gnt_i;
   assign bus.d_accept = gnt_d;

   always_comb begin
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 4'h0;
      bus.mem_addr  = bus.i_addr[AW+1:2];
      bus.mem_wdata = bus.d_wdata;
      if (gnt_d) begin
         bus.mem_addr = bus.d_addr[AW+1:2];
         if (d_inr) begin
            if (d_wr) begin
               bus.mem_wen = bus.d_wen;
            end else begin
               bus.mem_ren = 1'b1;
            end
         end
      end else if (gnt_i && i_inr) begin
         bus.mem_ren = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q    <= 1'b1;
         rsp_val_q <= 1'b0;
         rsp_src_q <= 1'b0;
         rsp_err_q <= 1'b0;
         rsp_tag_q <= 11'h0;
         rsp_pc_q  <= 32'h0;
         cnt_q     <= 16'h0;
      end else begin
         // Writes never produce a valid response; an out-of-range write still flags an error.
         rsp_val_q <= gnt_i | (gnt_d & ~d_wr);
         rsp_err_q <= (gnt_i & ~i_inr) | (gnt_d & ~d_inr);
         rsp_src_q <= gnt_d;
         if (gnt_d) begin
            rsp_tag_q <= bus.d_req_tag;
            prio_q    <= 1'b0;
         end else if (gnt_i) begin
            rsp_pc_q  <= bus.i_addr;
            prio_q    <= 1'b1;
         end
         if (i_act && d_act && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign i_val_w        = rsp_val_q & ~rsp_src_q;
   assign d_val_w        = rsp_val_q & rsp_src_q;
   assign bus.i_val      = i_val_w;
   assign bus.d_val      = d_val_w;
   assign bus.i_error    = rsp_err_q & ~rsp_src_q;
   assign bus.d_error    = rsp_err_q & rsp_src_q;
   assign bus.i_rdata    = (i_val_w && !rsp_err_q) ? bus.mem_rdata : 32'h0;
   assign bus.d_rdata    = (d_val_w && !rsp_err_q) ? bus.mem_rdata : 32'h0;
   assign bus.i_pc       = rsp_pc_q;
   assign bus.d_resp_tag = rsp_tag_q;
   assign bus.conflict_cnt = cnt_q;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, default 10: RAM word-address width (RAM depth 2^AW words).
REQ-002 Parameter MEM_START, default 32'h00000000: lowest legal byte address.
REQ-003 Parameter MEM_STOP, default 32'h00001000: first illegal byte address above MEM_START.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_ren  in  1 / i_addr  in  32  fetch request, byte address.
REQ-007 i_accept  out  1 / i_val  out  1 / i_error  out  1 / i_rdata  out  32 / i_pc  out  32  fetch handshake and response.
REQ-008 d_ren  in  1 / d_wen  in  4 / d_addr  in  32 / d_wdata  in  32 / d_req_tag  in  11  data request.
REQ-009 d_accept  out  1 / d_val  out  1 / d_error  out  1 / d_rdata  out  32 / d_resp_tag  out  11  data handshake and response.
REQ-010 mem_ren  out  1 / mem_wen  out  4 / mem_addr  out  AW / mem_wdata  out  32  single-port RAM command.
REQ-011 mem_rdata  in  32  RAM read data, valid exactly one cycle after mem_ren.
REQ-012 conflict_cnt  out  16  saturating count of cycles with both requesters active.

Function
REQ-013 Active request: i_ren for fetch; d_ren or |d_wen for data; d with both set is treated as a write.
REQ-014 In-range: MEM_START <= addr < MEM_STOP; out-of-range requests never drive mem_ren/mem_wen.
REQ-015 Grant is combinational in the request cycle; accept asserts same cycle as grant; non-granted requester sees accept=0 and holds its request.
REQ-016 Single active requester: granted immediately.
REQ-017 Both active: grant to side indicated by prio_q (1=d, 0=i); after any grant, prio_q points to the other side (round-robin).
REQ-018 Granted in-range access drives mem_addr=addr[AW+1:2], mem_wdata=d_wdata, mem_wen=d_wen (data write only), mem_ren=1 (fetch or data read); otherwise mem_ren=0, mem_wen=0.
REQ-019 Response pipeline: one registered stage (rsp_val_q, rsp_src_q, rsp_err_q, rsp_tag_q, rsp_pc_q); response latency exactly 1 cycle after accept.
REQ-020 Fetch response: i_val=1, i_rdata=mem_rdata, i_pc=registered i_addr, i_error=0; out-of-range: i_val=1, i_error=1, i_rdata=0.
REQ-021 Data read response: d_val=1, d_rdata=mem_rdata, d_resp_tag=registered tag, d_error=0; out-of-range: d_val=1, d_error=1, d_rdata=0.
REQ-022 Data write: no d_val; out-of-range write gives d_error=1, d_val=0 for one cycle after accept, with tag.
REQ-023 Responses carry no back-pressure; a new grant may issue every cycle (throughput 1 access/cycle).
REQ-024 Response outputs not currently valid are 0 (except d_resp_tag/i_pc, which hold last registered value).
REQ-025 conflict_cnt increments by 1 each cycle both requesters are active; saturates at 16'hFFFF, never wraps.
REQ-026 Address exactly MEM_STOP-4 is in range; MEM_STOP is out of range; byte offset bits [1:0] ignored.

Reset
REQ-027 rst_n=0 asynchronously clears: prio_q=1, rsp_val_q=0, rsp_err_q=0, rsp_tag_q=0, rsp_pc_q=0, conflict_cnt=0.
REQ-028 During reset all accept, val, error, mem_ren, mem_wen outputs are 0; rdata 0.
REQ-029 Reset mid-operation drops any pending response; no val is issued for a request accepted in the cycle reset asserts.
REQ-030 First cycle after deassert with both requesting grants d.

Verification
REQ-031 Both request at addr 0x10 after reset -> cycle0 d_accept=1,i_accept=0; cycle1 i_accept=1; conflict_cnt=1.
REQ-032 Fetch i_addr=0x20, RAM word 8 = 0xDEADBEEF -> mem_addr=8, next cycle i_val=1, i_rdata=0xDEADBEEF, i_pc=0x20.
REQ-033 Data read d_addr=0x1000, tag=0x155 -> no mem_ren; next cycle d_val=1, d_error=1, d_rdata=0, d_resp_tag=0x155.
REQ-034 Data write d_wen=4'b0011, d_addr=0xFFC, wdata=0x1234 -> mem_wen=0011, mem_addr=0x3FF, no d_val next cycle.
REQ-035 Both requesters active 70000 consecutive cycles -> grants alternate every cycle; conflict_cnt=0xFFFF and holds.
REQ-036 Assert rst_n=0 in cycle a read is accepted -> no d_val after release; prio_q=1, conflict_cnt=0.
